// File: rtl/i2c_cfg_pkg.sv
// Shared types and helpers for the I2C configuration sequencer.
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_STRT, S_SLAV, S_RADR, S_WDAT,
    S_ACK,  S_STOP, S_GAP,  S_DONE, S_FAIL
  } state_t;

  // Quarter-period phases of one bus bit.
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  function automatic int clog2(input int value);
    int r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // System clocks per SCL quarter-period for a given system/SCL frequency pair.
  function automatic int calc_clk_div_q(input int clk_hz, input int scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Open-drain I2C bus: output enables from the master, pin readbacks from the pads.
interface i2c_cfg_sequencer_if;
  logic scl_oe;
  logic sda_oe;
  logic scl_in;
  logic sda_in;

  modport master (output scl_oe, sda_oe, input scl_in, sda_in);
  modport slave  (input scl_oe, sda_oe, output scl_in, sda_in);
endinterface

// File: rtl/i2c_qtick_gen.sv
// SCL quarter-period divider: one-cycle qtick every CLK_DIV_Q clocks plus a 2-bit bit phase.
module i2c_qtick_gen
  import i2c_cfg_pkg::*;
#(
  parameter int CLK_DIV_Q = 25
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       hold,
  output logic       qtick,
  output logic [1:0] phase
);
  localparam int CNT_W = clog2(CLK_DIV_Q);

  logic [CNT_W-1:0] cnt;

  assign qtick = (cnt == CNT_W'(CLK_DIV_Q - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= P0;
    end else if (clear) begin
      cnt   <= '0;
      phase <= P0;
    end else if (hold) begin
      cnt   <= '0;
    end else if (qtick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Write-only I2C master that loads NUM_REGS (register, data) pairs into one 7-bit slave.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int         CLK_DIV_Q = 25,
  parameter int         NUM_REGS  = 11,
  parameter int         IDX_W     = 4,
  parameter logic [6:0] SLV_ADDR7 = 7'h55,
  parameter int         MAX_RETRY = 3
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic                start,
  output logic [IDX_W-1:0]    tbl_idx,
  input  logic [7:0]          tbl_raddr,
  input  logic [7:0]          tbl_wdata,
  i2c_cfg_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    err_idx
);
  localparam int         RETRY_W  = (MAX_RETRY > 0) ? clog2(MAX_RETRY + 1) : 1;
  localparam logic [7:0] SLV_BYTE = {SLV_ADDR7, 1'b0};

  state_t             state, state_d, ack_next, ack_next_d;
  logic [IDX_W-1:0]   tbl_idx_d, err_idx_d;
  logic [RETRY_W-1:0] retry, retry_d;
  logic [2:0]         bit_cnt, bit_cnt_d;
  logic               ok_flag, ok_d, sda_smp, sda_smp_d, done_d, err_d, ready;
  logic               qtick, bit_end, idle, hold, hold_req, scl_drive, sda_drive;
  logic [1:0]         phase;
  logic [7:0]         tx_byte;

  assign idle    = state inside {S_IDLE, S_DONE, S_FAIL};
  assign busy    = !idle;
  assign bit_end = qtick && (phase == P3);

  // The divider is parked while idle so the first STRT quarter is a full one.
  i2c_qtick_gen #(.CLK_DIV_Q(CLK_DIV_Q)) u_qtick (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .clear   (idle),
    .hold    (hold),
    .qtick   (qtick),
    .phase   (phase)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ack_next <= S_IDLE;
      tbl_idx  <= '0;
      err_idx  <= '0;
      retry    <= '0;
      bit_cnt  <= '0;
      ok_flag  <= 1'b0;
      sda_smp  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      ready    <= 1'b0;
    end else begin
      state    <= state_d;
      ack_next <= ack_next_d;
      tbl_idx  <= tbl_idx_d;
      err_idx  <= err_idx_d;
      retry    <= retry_d;
      bit_cnt  <= bit_cnt_d;
      ok_flag  <= ok_d;
      sda_smp  <= sda_smp_d;
      done     <= done_d;
      err      <= err_d;
      ready    <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state;
    ack_next_d = ack_next;
    tbl_idx_d  = tbl_idx;
    err_idx_d  = err_idx;
    retry_d    = retry;
    bit_cnt_d  = bit_cnt;
    ok_d       = ok_flag;
    sda_smp_d  = sda_smp;
    done_d     = done;
    err_d      = err;
    if (qtick && (phase == P2)) sda_smp_d = bus.sda_in;

    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        // ready blocks a START landing on the first edge after reset release.
        if (start && ready) begin
          state_d   = S_STRT;
          tbl_idx_d = '0;
          retry_d   = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_STRT: if (bit_end) begin
        state_d   = S_SLAV;
        bit_cnt_d = '0;
      end
      S_SLAV, S_RADR, S_WDAT: if (bit_end) begin
        bit_cnt_d = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          state_d    = S_ACK;
          ack_next_d = (state == S_SLAV) ? S_RADR : (state == S_RADR) ? S_WDAT : S_STOP;
        end
      end
      S_ACK: if (bit_end) begin
        bit_cnt_d = '0;
        if (sda_smp) begin
          ok_d    = 1'b0;
          state_d = S_STOP;
        end else begin
          ok_d    = (ack_next == S_STOP);
          state_d = ack_next;
        end
      end
      S_STOP: if (bit_end) state_d = S_GAP;
      S_GAP: if (bit_end) begin
        if (ok_flag) begin
          if (tbl_idx == IDX_W'(NUM_REGS - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            tbl_idx_d = tbl_idx + 1'b1;
            retry_d   = '0;
            state_d   = S_STRT;
          end
        end else if (retry < RETRY_W'(MAX_RETRY)) begin
          retry_d = retry + 1'b1;
          state_d = S_STRT;
        end else begin
          state_d   = S_FAIL;
          err_d     = 1'b1;
          err_idx_d = tbl_idx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      S_SLAV:  tx_byte = SLV_BYTE;
      S_RADR:  tx_byte = tbl_raddr;
      default: tx_byte = tbl_wdata;
    endcase
  end

  // Bus drive decoded from registered state so reset releases both lines at once.
  always_comb begin
    scl_drive = 1'b0;
    sda_drive = 1'b0;
    hold_req  = 1'b0;
    case (state)
      S_STRT: begin
        sda_drive = phase[1];
        hold_req  = 1'b1;
      end
      S_SLAV, S_RADR, S_WDAT: begin
        scl_drive = !phase[1];
        sda_drive = !tx_byte[3'd7 - bit_cnt];
        hold_req  = (phase == P2);
      end
      S_ACK: begin
        scl_drive = !phase[1];
        hold_req  = (phase == P2);
      end
      S_STOP: begin
        scl_drive = (phase == P0);
        sda_drive = !phase[1];
        hold_req  = (phase != P0);
      end
      default: ;
    endcase
  end

  assign bus.scl_oe = scl_drive;
  assign bus.sda_oe = sda_drive;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = hold_req && !bus.scl_in;
`else
  logic stretch_unused;
  assign stretch_unused = hold_req | bus.scl_in;
  assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Randomized bench for i2c_cfg_sequencer: bus-level slave/monitor plus a transaction-level reference model.
module tb_i2c_cfg_sequencer;
  localparam int         Q         = 6;
  localparam int         NUM_REGS  = 3;
  localparam int         IDX_W     = 4;
  localparam int         MAX_RETRY = 3;
  localparam logic [6:0] SLV       = 7'h55;
  localparam int         LIMIT     = 20000;

  logic             clock_in = 1'b0;
  logic             reset_n  = 1'b0;
  logic             start    = 1'b0;
  logic [IDX_W-1:0] tbl_idx, err_idx;
  logic [7:0]       tbl_raddr, tbl_wdata;
  logic             busy, done, err;
  logic [7:0]       tr [16];
  logic [7:0]       tw [16];

  i2c_cfg_sequencer_if bus();

  i2c_cfg_sequencer #(
    .CLK_DIV_Q(Q), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .SLV_ADDR7(SLV), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .start    (start),
    .tbl_idx  (tbl_idx),
    .tbl_raddr(tbl_raddr),
    .tbl_wdata(tbl_wdata),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_idx  (err_idx)
  );

  always #5 clock_in = ~clock_in;

  assign tbl_raddr = tr[tbl_idx];
  assign tbl_wdata = tw[tbl_idx];

  logic slave_pull = 1'b0;
  assign bus.sda_in = !(bus.sda_oe || slave_pull);
`ifdef I2C_CLK_STRETCH_EN
  int   stretch_cnt = 0;
  logic stretch_req = 1'b0;
  assign bus.scl_in = !(bus.scl_oe || (stretch_cnt > 0));
`else
  assign bus.scl_in = !bus.scl_oe;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs.
  logic [31:0] nack_addr_mask = '0;
  logic [31:0] nack_wdat_mask = '0;
  logic        radr_nack_en   = 1'b0;
  logic [7:0]  radr_nack_val  = '0;

  function automatic bit want_ack(input int att, input int b, input logic [7:0] v);
    if (b == 0) return (v == 8'hAA) && (att >= 32 || !nack_addr_mask[att[4:0]]);
    if (b == 1) return !(radr_nack_en && v == radr_nack_val);
    return att >= 32 || !nack_wdat_mask[att[4:0]];
  endfunction

  // Bus monitor + slave, sampling the wires on the falling system-clock edge.
  logic        mon_en = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1, m_scl, m_sda;
  int          nb = 0, byte_no = 0, att = 0, starts = 0;
  logic [7:0]  shreg = '0;
  logic [31:0] cur_word = '0;
  logic [31:0] obs_q[$];

  always @(negedge clock_in) begin
    m_scl = bus.scl_in;
    m_sda = bus.sda_in;
    if (!mon_en) begin
      nb = 0; byte_no = 0; att = 0; starts = 0; slave_pull = 1'b0;
      obs_q.delete();
    end else if (m_scl && prev_scl && prev_sda && !m_sda) begin
      nb = 0; byte_no = 0; cur_word = '0; starts++;
    end else if (m_scl && prev_scl && !prev_sda && m_sda) begin
      obs_q.push_back({8'(byte_no), cur_word[23:0]});
      att++;
      slave_pull = 1'b0;
    end else if (m_scl && !prev_scl) begin
      if (nb == 8) begin
        if (byte_no < 3) cur_word[23 - 8*byte_no -: 8] = shreg;
        byte_no++;
        nb = 0;
      end else begin
        shreg = {shreg[6:0], m_sda};
        nb++;
      end
    end else if (!m_scl && prev_scl) begin
      if (nb == 8) slave_pull = want_ack(att, byte_no, shreg);
      else if (nb == 0) slave_pull = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      if (stretch_req && att == 0 && byte_no == 0 && nb == 4) stretch_cnt = 501 + 2*Q;
`endif
    end
    prev_scl = m_scl;
    prev_sda = m_sda;
`ifdef I2C_CLK_STRETCH_EN
    if (stretch_cnt > 0) stretch_cnt--;
`endif
  end

  // Reference model: attempts per entry as whole transactions, plus qtick budget.
  logic [31:0] exp_q[$];
  int          exp_qt, exp_err_idx;
  bit          exp_done, exp_err;

  task automatic build_exp();
    int a, sent;
    bit ok;
    logic [7:0]  by [3];
    logic [31:0] w;
    exp_q.delete();
    exp_qt = 0; exp_done = 0; exp_err = 0; exp_err_idx = 0; a = 0;
    for (int e = 0; e < NUM_REGS; e++) begin
      ok = 0;
      for (int r = 0; r <= MAX_RETRY && !ok; r++) begin
        by[0] = 8'hAA; by[1] = tr[e]; by[2] = tw[e];
        w = '0; sent = 0; ok = 1;
        for (int b = 0; b < 3 && ok; b++) begin
          w[23 - 8*b -: 8] = by[b];
          sent++;
          ok = want_ack(a, b, by[b]);
        end
        w[31:24] = 8'(sent);
        exp_q.push_back(w);
        exp_qt += 4 + 36*sent + 8;
        a++;
      end
      if (!ok) begin
        exp_err = 1; exp_err_idx = e;
        return;
      end
    end
    exp_done = 1;
  endtask

  task automatic arm_monitor();
    mon_en = 1'b0;
    @(negedge clock_in);
    @(negedge clock_in);
    mon_en = 1'b1;
  endtask

  task automatic run_and_check(input string name, input int extra);
    int c;
    build_exp();
    arm_monitor();
    start = 1'b1;
    @(posedge clock_in);
    @(negedge clock_in);
    start = 1'b0;
    check({name, "_busy_on_start"}, busy, 1'b1);
    check({name, "_sticky_cleared"}, {done, err}, 2'b00);
    c = 0;
    while (c < LIMIT) begin
      if (done || err) break;
      start = busy && ($urandom_range(0, 299) == 0);
      @(posedge clock_in);
      c++;
      @(negedge clock_in);
    end
    start = 1'b0;
    check({name, "_cycles"}, c, exp_qt*Q + extra);
    check({name, "_done"}, done, exp_done);
    check({name, "_err"}, err, exp_err);
    check({name, "_busy_end"}, busy, 1'b0);
    check({name, "_bus_released"}, {bus.scl_oe, bus.sda_oe}, 2'b00);
    check({name, "_tbl_idx"}, tbl_idx, exp_done ? NUM_REGS - 1 : exp_err_idx);
    if (exp_err) check({name, "_err_idx"}, err_idx, exp_err_idx);
    check({name, "_starts"}, starts, exp_q.size());
    check({name, "_n_xfers"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({name, "_xfer"}, (i < obs_q.size()) ? obs_q[i] : 32'hFFFF_FFFF, exp_q[i]);
  endtask

  task automatic load_plan_table();
    tr[0] = 8'h84; tw[0] = 8'h00;
    tr[1] = 8'h00; tw[1] = 8'h23;
    tr[2] = 8'h05; tw[2] = 8'h29;
  endtask

  task automatic clear_nacks();
    nack_addr_mask = '0; nack_wdat_mask = '0; radr_nack_en = 1'b0; radr_nack_val = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tr[i] = '0;
      tw[i] = '0;
    end
    #1;
    check("rst_bus", {bus.scl_oe, bus.sda_oe}, 2'b00);
    check("rst_flags", {busy, done, err}, 3'b000);
    check("rst_idx", {tbl_idx, err_idx}, '0);

    repeat (3) @(negedge clock_in);
    reset_n = 1'b1;
    start   = 1'b1;
    @(posedge clock_in);
    @(negedge clock_in);
    start = 1'b0;
    check("start_at_rst_release", busy, 1'b0);

    load_plan_table();
    clear_nacks();
    run_and_check("all_ack", 0);

    nack_addr_mask = 32'b110;
    run_and_check("addr_nack_retry", 0);

    clear_nacks();
    radr_nack_en = 1'b1; radr_nack_val = 8'h00;
    run_and_check("radr_nack_fail", 0);

    // Reset in the middle of entry 1's register-address byte, then rerun.
    clear_nacks();
    arm_monitor();
    start = 1'b1;
    @(posedge clock_in);
    @(negedge clock_in);
    start = 1'b0;
    for (int i = 0; i < LIMIT && !(starts == 2 && byte_no == 1 && nb >= 3); i++)
      @(negedge clock_in);
    check("mid_radr_reached", byte_no, 1);
    check("mid_radr_idx", tbl_idx, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_bus", {bus.scl_oe, bus.sda_oe}, 2'b00);
    check("async_rst_flags", {busy, done, err, tbl_idx}, '0);
    @(negedge clock_in);
    reset_n = 1'b1;
    run_and_check("rerun_after_rst", 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tr[i] = 8'($urandom);
        tw[i] = 8'($urandom);
      end
      nack_addr_mask = $urandom & $urandom & $urandom;
      nack_wdat_mask = $urandom & $urandom & $urandom;
      radr_nack_en   = ($urandom_range(0, 3) == 0);
      radr_nack_val  = tr[$urandom_range(0, NUM_REGS - 1)];
      run_and_check("random", 0);
    end

`ifdef I2C_CLK_STRETCH_EN
    load_plan_table();
    clear_nacks();
    stretch_req = 1'b1;
    run_and_check("stretch", 500);
    stretch_req = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
